// File: rtl/motor_pwm.sv
// motor_pwm: H-bridge drive from a 2-bit motor command, with soft-start duty ramp, reversal dead time and period-aligned duty updates.
// Optional feature macro: MOTOR_RAMP_EN (soft-start ramp); when undefined, duty jumps straight to DUTY_MAX.
module motor_pwm #(
    parameter int PERIOD       = 1000,
    parameter int DUTY_START   = 300,
    parameter int DUTY_MAX     = 800,
    parameter int RAMP_STEP    = 25,
    parameter int DEAD_PERIODS = 2
) (
    input  logic        clkus,
    input  logic        rst,
    input  logic [1:0]  motor,
    output logic        in1,
    output logic        in2,
    output logic        pwm,
    output logic [15:0] duty,
    output logic        settled
);
    typedef enum logic [2:0] {IDLE, FWD, REV, DEAD, BRAKE} state_t;

    localparam logic [15:0] P_LAST = 16'(PERIOD - 1);
    localparam logic [15:0] D_MAX  = 16'(DUTY_MAX);
    localparam logic [15:0] D_DEAD = 16'(DEAD_PERIODS);

    if (DUTY_START > DUTY_MAX || DUTY_MAX > PERIOD || RAMP_STEP < 1 || DEAD_PERIODS < 1) begin : g_bad_params
        $error("motor_pwm: inconsistent parameters");
    end

    state_t      state, state_n, target, target_n;
    logic [1:0]  motor_q;
    logic [15:0] pcnt, pcnt_n, duty_n, dead_cnt, dead_cnt_n, duty_step, d_load;
    logic        wrap, changed, drive_n;

`ifdef MOTOR_RAMP_EN
    logic [16:0] sum;
    assign sum       = {1'b0, duty} + 17'(RAMP_STEP);
    assign duty_step = sum > 17'(DUTY_MAX) ? D_MAX : sum[15:0];
    assign d_load    = 16'(DUTY_START);
`else
    assign duty_step = duty;
    assign d_load    = D_MAX;
`endif

    always_comb begin
        wrap     = pcnt == P_LAST;
        state_n  = state;
        target_n = target;
        case (state)
            IDLE:  state_n = motor_q == 2'b01 ? FWD : motor_q == 2'b10 ? REV : motor_q == 2'b11 ? BRAKE : IDLE;
            FWD:   state_n = motor_q == 2'b00 ? IDLE : motor_q == 2'b11 ? BRAKE : motor_q == 2'b10 ? DEAD : FWD;
            REV:   state_n = motor_q == 2'b00 ? IDLE : motor_q == 2'b11 ? BRAKE : motor_q == 2'b01 ? DEAD : REV;
            BRAKE: state_n = motor_q == 2'b00 ? IDLE : motor_q == 2'b01 ? FWD : motor_q == 2'b10 ? REV : BRAKE;
            DEAD: begin
                target_n = motor_q == 2'b01 ? FWD : motor_q == 2'b10 ? REV : target;
                state_n  = motor_q == 2'b00 ? IDLE : motor_q == 2'b11 ? BRAKE :
                           (wrap && dead_cnt == 16'd1) ? target_n : DEAD;
            end
            default: state_n = IDLE;
        endcase
        if (state != DEAD)
            target_n = state == FWD ? REV : FWD;
        changed    = state_n != state;
        pcnt_n     = (changed || wrap) ? 16'd0 : pcnt + 16'd1;
        drive_n    = state_n == FWD || state_n == REV;
        // A command change wins over the boundary ramp step.
        duty_n     = !drive_n ? 16'd0 : changed ? d_load : wrap ? duty_step : duty;
        dead_cnt_n = state_n != DEAD ? 16'd0 : changed ? D_DEAD : wrap ? dead_cnt - 16'd1 : dead_cnt;
    end

    always_ff @(posedge clkus) begin
        if (rst) begin
            state    <= IDLE;
            target   <= FWD;
            motor_q  <= 2'b00;
            pcnt     <= '0;
            dead_cnt <= '0;
            duty     <= '0;
            in1      <= 1'b0;
            in2      <= 1'b0;
            pwm      <= 1'b0;
            settled  <= 1'b0;
        end else begin
            state    <= state_n;
            target   <= target_n;
            motor_q  <= motor;
            pcnt     <= pcnt_n;
            dead_cnt <= dead_cnt_n;
            duty     <= duty_n;
            in1      <= state_n == FWD || state_n == BRAKE;
            in2      <= state_n == REV || state_n == BRAKE;
            pwm      <= state_n == BRAKE || (drive_n && pcnt_n < duty_n);
            settled  <= drive_n && duty_n == D_MAX;
        end
    end
endmodule

// File: doc/motor_pwm.md
# motor_pwm

Motor drive stage directly downstream of the tracking/u-turn logic. It consumes the 2-bit motor command (00 stop, 01 forward, 10 backward, 11 brake) and produces the H-bridge direction pins plus a PWM enable. The block adds a soft-start duty ramp, a coast dead time on every direction reversal, and glitch-free duty updates at PWM period boundaries.

## Interface

Parameters:
- PERIOD, 1000: PWM period in clkus cycles (1 kHz at 1 MHz).
- DUTY_START, 300: duty, in cycles, on entry to a drive state.
- DUTY_MAX, 800: saturation duty; must satisfy DUTY_START ≤ DUTY_MAX ≤ PERIOD.
- RAMP_STEP, 25: duty increment per completed period.
- DEAD_PERIODS, 2: full coast periods inserted on a reversal.

Ports:
- clkus input 1: 1 MHz clock. It is the only clock.
- rst input 1: reset, synchronous, active-high.
- motor input 2: command from the tracking/u-turn stage; sampled every cycle.
- in1 output 1: H-bridge direction A.
- in2 output 1: H-bridge direction B.
- pwm output 1: H-bridge enable.
- duty output 16: current duty register, for debug.
- settled output 1: high while in FWD/REV with duty == DUTY_MAX.

## Operation

- States: IDLE, FWD, REV, DEAD, BRAKE.
- Pin mapping by state:
  - IDLE and DEAD: in1=0, in2=0, pwm=0 (coast).
  - FWD: in1=1, in2=0.
  - REV: in1=0, in2=1.
  - BRAKE: in1=1, in2=1, pwm=1.
- In FWD and REV, pwm = (pcnt < duty).
- pcnt is a 16-bit counter running 0..PERIOD-1 and wrapping to 0. It clears to 0 on every state change.
- Transitions:
  - IDLE: 01→FWD, 10→REV, 11→BRAKE, 00→stay.
  - FWD: 00→IDLE, 11→BRAKE, 10→DEAD (target REV), 01→stay.
  - REV: 00→IDLE, 11→BRAKE, 01→DEAD (target FWD), 10→stay.
  - DEAD:
    - 00→IDLE immediately; 11→BRAKE immediately.
    - 01/10 overwrite the target; DEAD does not restart.
    - After DEAD_PERIODS complete periods, enter the target state.
  - BRAKE: 00→IDLE, 01→FWD, 10→REV (no dead time; the bridge is already shorted).
- Duty:
  - Loads DUTY_START on entry to FWD or REV.
  - In FWD/REV at pcnt == PERIOD-1: duty ← min(duty + RAMP_STEP, DUTY_MAX). The sum is computed at 17 bits and saturates.
  - duty is 0 in IDLE, DEAD and BRAKE.
  - duty changes only at a period boundary, except on entry or exit of a drive state.
- dead_cnt:
  - Loads DEAD_PERIODS on entry to DEAD.
  - Decrements at pcnt == PERIOD-1.
  - Exit from DEAD occurs on the boundary where dead_cnt reaches 1.

## Timing

- All outputs are registered.
- A command change present before clkus edge N is reflected on in1/in2/pwm/duty after edge N+1 (1-cycle latency).
- Reset values: in1=0, in2=0, pwm=0, duty=0, settled=0, state IDLE, pcnt=0, dead_cnt=0.
- rst asserted mid-operation forces all of the above on the next edge, regardless of motor.
- Reversal FWD→REV: coast lasts DEAD_PERIODS×PERIOD cycles (2000), counted from the first DEAD cycle.
- First REV cycle: pwm=1, duty=DUTY_START.
- Ramp from DUTY_START to DUTY_MAX takes ceil((DUTY_MAX−DUTY_START)/RAMP_STEP) periods (20 by default).
- In FWD/REV with duty=d, pwm is high for exactly d cycles per period, including d=PERIOD (always high).
- Simultaneous events:
  - A command change on a period-boundary cycle takes priority over the ramp update.
  - rst takes priority over everything.

## Configuration

- MOTOR_RAMP_EN defined: soft-start ramp as described above.
- MOTOR_RAMP_EN undefined:
  - duty loads DUTY_MAX directly on entry to FWD/REV, and no ramp logic is built.
  - settled is high on every FWD/REV cycle.
  - Dead time and all other behaviour are unchanged.

## Test plan

- Reset: assert rst for 3 cycles with motor=01 → in1=in2=pwm=0, duty=0 throughout; state IDLE after release with motor=00.
- Forward ramp: motor=01 from IDLE →
  - in1=1, in2=0 after 1 cycle; duty=300 with pwm high for 300 of 1000 cycles.
  - duty=325 in the next period.
  - settled=1 after 20 periods with duty=800, no further change.
- Reversal: motor 01→10 while in FWD →
  - 2000 cycles with in1=in2=pwm=0.
  - Then in2=1, duty=300.
  - Flip motor back to 01 at DEAD cycle 500: DEAD still ends at cycle 2000, entering FWD.
- Brake and stop:
  - motor=11 from REV → next cycle in1=in2=pwm=1, duty=0.
  - motor=00 → next cycle all 0.
  - motor=10 from BRAKE → REV next cycle, no coast.
- Macro off (MOTOR_RAMP_EN undefined): motor=01 → duty=800 and settled=1 on the first FWD cycle.
- Reset mid-ramp: rst at period 7 of FWD → outputs 0 next cycle; motor=01 after release restarts at duty=300.
